// File: rtl/rob_commit.sv
// rob_commit
//   Commit stage of the reorder buffer. Each cycle it inspects the ROB head
//   entry and either retires it (register write), drives it through the
//   data-cache write port (store), flushes and redirects (exception), or waits.
//   It owns the ROB head/tail pointers and drives the ROB head write port.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   state_head ..      : ROB head entry read port (state, addr, value, PC,
//     mode_head          instruction, mode)
//   empty_entries      : number of free ROB entries
//   alloc              : decode allocates one entry at the tail this cycle
//   head, tail         : ROB pointers (registered)
//   write_head         : head write mask {state,mode,addr,value,PC,instr}
//   state_head_write   : new state written into the head entry
//   rf_we/waddr/wdata  : register file write port
//   dcache_wr_*        : data-cache write request/address/data, done input
//   flush              : clears ROB and younger pipeline stages
//   redirect_valid/pc  : fetch redirect to the exception vector
//   epc, epc_mode      : PC and mode of the last excepting instruction
//   retired_count      : number of instructions retired (wraps at 2^32)
module rob_commit #(
   parameter int unsigned ROB_WIDTH          = 3,
   parameter int unsigned DATA_SIZE          = 32,
   parameter int unsigned VIRTUAL_ADDR_WIDTH = 32,
   parameter int unsigned INSTRUCTION_WIDTH  = 32,
   parameter int unsigned MODE_WIDTH         = 1,
   parameter logic [VIRTUAL_ADDR_WIDTH-1:0] EXC_VECTOR = 32'h2000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [2:0]                    state_head,
   input  logic [VIRTUAL_ADDR_WIDTH-1:0] addr_head,
   input  logic [DATA_SIZE-1:0]          value_head,
   input  logic [VIRTUAL_ADDR_WIDTH-1:0] PC_head,
   input  logic [INSTRUCTION_WIDTH-1:0]  instr_head,
   input  logic [MODE_WIDTH-1:0]         mode_head,
   input  logic [ROB_WIDTH:0]            empty_entries,
   input  logic                          alloc,
   output logic [ROB_WIDTH-1:0]          head,
   output logic [ROB_WIDTH-1:0]          tail,
   output logic [5:0]                    write_head,
   output logic [2:0]                    state_head_write,
   output logic                          rf_we,
   output logic [4:0]                    rf_waddr,
   output logic [DATA_SIZE-1:0]          rf_wdata,
   output logic                          dcache_wr_req,
   output logic [VIRTUAL_ADDR_WIDTH-1:0] dcache_wr_addr,
   output logic [DATA_SIZE-1:0]          dcache_wr_data,
   input  logic                          dcache_wr_done,
   output logic                          flush,
   output logic                          redirect_valid,
   output logic [VIRTUAL_ADDR_WIDTH-1:0] redirect_pc,
   output logic [VIRTUAL_ADDR_WIDTH-1:0] epc,
   output logic [MODE_WIDTH-1:0]         epc_mode,
   output logic [31:0]                   retired_count
);

   // ROB entry states as stored in the ROB
   typedef enum logic [2:0] {
      RS_UNUSED          = 3'd0,
      RS_BUSY            = 3'd1,
      RS_EXCEPTION       = 3'd2,
      RS_WAITING_CACHE   = 3'd3,
      RS_ACCESSING_CACHE = 3'd4,
      RS_COMPLETE        = 3'd5
   } rob_state_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STORE,
      S_FLUSH
   } fsm_e;

   localparam logic [5:0] WH_STATE_ONLY = 6'b100000;

   // Instruction decode shared with the rest of the pipeline (MIPS-I).
   // Destination-writing classes:
   //   R-type (except JR, SYSCALL, BREAK, MTHI, MTLO, MULT/MULTU/DIV/DIVU) -> rd
   //   JAL -> $31
   //   I-type ALU (opcodes 0x08..0x0F) and loads (0x20..0x26) -> rt
   function automatic logic has_rw(input logic [INSTRUCTION_WIDTH-1:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      logic       res;
      op  = ins[31:26];
      fn  = ins[5:0];
      res = 1'b0;
      if (op == 6'h00) begin
         case (fn)
            6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13,
            6'h18, 6'h19, 6'h1A, 6'h1B: res = 1'b0;
            default:                    res = 1'b1;
         endcase
      end else if (op == 6'h03) begin
         res = 1'b1;
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         res = 1'b1;
      end else if (op >= 6'h20 && op <= 6'h26) begin
         res = 1'b1;
      end
      return res;
   endfunction

   function automatic logic [4:0] get_rw(input logic [INSTRUCTION_WIDTH-1:0] ins);
      logic [5:0] op;
      logic [4:0] res;
      op = ins[31:26];
      if (op == 6'h00)      res = ins[15:11];
      else if (op == 6'h03) res = 5'd31;
      else                  res = ins[20:16];
      return res;
   endfunction

   fsm_e                          r_state;
   logic [ROB_WIDTH-1:0]          r_head;
   logic [ROB_WIDTH-1:0]          r_tail;
   logic [VIRTUAL_ADDR_WIDTH-1:0] r_epc;
   logic [MODE_WIDTH-1:0]         r_epc_mode;
   logic [31:0]                   r_retired;

   logic w_retire;
   logic w_alloc_ok;
   logic w_has_rw;
   logic [4:0] w_rw;

   assign w_has_rw = has_rw(instr_head);
   assign w_rw     = get_rw(instr_head);

   // One retire per cycle: either an ALU result at head, or a store's done.
   assign w_retire = ((r_state == S_IDLE) && (state_head == RS_COMPLETE)) ||
                     ((r_state == S_STORE) && dcache_wr_done);

   // Allocation is dropped while full or during the flush cycle.
   assign w_alloc_ok = alloc && (empty_entries != '0) && (r_state != S_FLUSH);

   assign head          = r_head;
   assign tail          = r_tail;
   assign epc           = r_epc;
   assign epc_mode      = r_epc_mode;
   assign retired_count = r_retired;

   always_comb begin
      write_head       = '0;
      state_head_write = RS_UNUSED;
      rf_we            = 1'b0;
      rf_waddr         = '0;
      rf_wdata         = '0;
      dcache_wr_req    = 1'b0;
      dcache_wr_addr   = '0;
      dcache_wr_data   = '0;
      flush            = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      case (r_state)
         S_IDLE: begin
            if (state_head == RS_COMPLETE) begin
               write_head       = WH_STATE_ONLY;
               state_head_write = RS_UNUSED;
               if (w_has_rw) begin
                  rf_we    = 1'b1;
                  rf_waddr = w_rw;
                  rf_wdata = value_head;
               end
            end else if (state_head == RS_WAITING_CACHE) begin
               write_head       = WH_STATE_ONLY;
               state_head_write = RS_ACCESSING_CACHE;
            end
         end
         S_STORE: begin
            dcache_wr_req  = 1'b1;
            dcache_wr_addr = addr_head;
            dcache_wr_data = value_head;
            if (dcache_wr_done) begin
               write_head       = WH_STATE_ONLY;
               state_head_write = RS_UNUSED;
            end
         end
         S_FLUSH: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = EXC_VECTOR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_head     <= '0;
         r_tail     <= '0;
         r_epc      <= '0;
         r_epc_mode <= '0;
         r_retired  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (state_head == RS_WAITING_CACHE) begin
                  r_state <= S_STORE;
               end else if (state_head == RS_EXCEPTION) begin
                  r_epc      <= PC_head;
                  r_epc_mode <= mode_head;
                  r_state    <= S_FLUSH;
               end
            end
            S_STORE: begin
               if (dcache_wr_done) r_state <= S_IDLE;
            end
            S_FLUSH: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Retire never coincides with FLUSH, so the flush clear cannot collide.
         if (r_state == S_FLUSH) begin
            r_head <= '0;
         end else if (w_retire) begin
            r_head    <= r_head + ROB_WIDTH'(1);
            r_retired <= r_retired + 32'd1;
         end

         if (r_state == S_FLUSH) begin
            r_tail <= '0;
         end else if (w_alloc_ok) begin
            r_tail <= r_tail + ROB_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  state_head;
   logic [31:0] addr_head, value_head, PC_head, instr_head;
   logic [0:0]  mode_head;
   logic [3:0]  empty_entries;
   logic        alloc;
   logic [2:0]  head, tail;
   logic [5:0]  write_head;
   logic [2:0]  state_head_write;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        dcache_wr_req;
   logic [31:0] dcache_wr_addr, dcache_wr_data;
   logic        dcache_wr_done;
   logic        flush, redirect_valid;
   logic [31:0] redirect_pc, epc;
   logic [0:0]  epc_mode;
   logic [31:0] retired_count;

   rob_commit #(
      .ROB_WIDTH(3), .DATA_SIZE(32), .VIRTUAL_ADDR_WIDTH(32),
      .INSTRUCTION_WIDTH(32), .MODE_WIDTH(1), .EXC_VECTOR(32'h2000)
   ) dut (
      .clk(clk), .reset(reset),
      .state_head(state_head), .addr_head(addr_head), .value_head(value_head),
      .PC_head(PC_head), .instr_head(instr_head), .mode_head(mode_head),
      .empty_entries(empty_entries), .alloc(alloc),
      .head(head), .tail(tail), .write_head(write_head),
      .state_head_write(state_head_write),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
      .dcache_wr_data(dcache_wr_data), .dcache_wr_done(dcache_wr_done),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .epc(epc), .epc_mode(epc_mode), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: pointers as plain integers modulo 8
   int          m_head, m_tail;
   int unsigned m_cnt;
   int unsigned m_epc;
   int          m_mode;
   bit          take;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string where);
      chk({where, ".head"}, 64'(head), 64'(m_head));
      chk({where, ".tail"}, 64'(tail), 64'(m_tail));
      chk({where, ".retired"}, 64'(retired_count), 64'(m_cnt));
      chk({where, ".epc"}, 64'(epc), 64'(m_epc));
      chk({where, ".epc_mode"}, 64'(epc_mode), 64'(m_mode));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      state_head     = 3'd0;
      alloc          = 1'b0;
      empty_entries  = 4'd8;
      dcache_wr_done = 1'b0;
      addr_head      = '0;
      value_head     = '0;
      PC_head        = '0;
      instr_head     = '0;
      mode_head      = '0;
   endtask

   task automatic rand_alloc();
      alloc         = 1'($urandom_range(0, 1));
      empty_entries = 4'($urandom_range(0, 8));
   endtask

   // alloc accepted unless full or the cycle is the flush cycle
   task automatic note_alloc(input bit flushing);
      take = alloc && (empty_entries != 0) && !flushing;
   endtask

   task automatic apply_alloc();
      if (take) m_tail = (m_tail + 1) % 8;
   endtask

   // Build an instruction of a given class; expected destination follows the
   // MIPS meaning of each class rather than field decoding.
   task automatic gen_instr(input int kind, output logic [31:0] ins,
                            output bit has, output int rd);
      logic [4:0] rs, rt, rdf;
      logic [15:0] imm;
      int alu_fn [19] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A,
                          'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h10, 'h12, 'h09};
      int nod_fn [9]  = '{'h08, 'h0C, 'h0D, 'h11, 'h13, 'h18, 'h19, 'h1A, 'h1B};
      int fn, op;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rdf = 5'($urandom);
      imm = 16'($urandom);
      case (kind)
         0: begin  // R-type producing rd
            fn = alu_fn[$urandom_range(0, 18)];
            ins = {6'h00, rs, rt, rdf, 5'($urandom), 6'(fn)};
            has = 1; rd = int'(rdf);
         end
         1: begin  // R-type with no GPR result
            fn = nod_fn[$urandom_range(0, 8)];
            ins = {6'h00, rs, rt, rdf, 5'($urandom), 6'(fn)};
            has = 0; rd = 0;
         end
         2: begin  // I-type ALU
            op = $urandom_range('h08, 'h0F);
            ins = {6'(op), rs, rt, imm};
            has = 1; rd = int'(rt);
         end
         3: begin  // load
            op = $urandom_range('h20, 'h26);
            ins = {6'(op), rs, rt, imm};
            has = 1; rd = int'(rt);
         end
         4: begin  // store
            op = $urandom_range('h28, 'h2B);
            ins = {6'(op), rs, rt, imm};
            has = 0; rd = 0;
         end
         5: begin  // branch
            op = $urandom_range('h04, 'h07);
            ins = {6'(op), rs, rt, imm};
            has = 0; rd = 0;
         end
         6: begin  // J
            ins = {6'h02, 26'($urandom)};
            has = 0; rd = 0;
         end
         default: begin  // JAL
            ins = {6'h03, 26'($urandom)};
            has = 1; rd = 31;
         end
      endcase
   endtask

   logic [31:0] ins;
   bit          has;
   int          rd;

   initial begin
      quiet_inputs();
      reset = 1'b1;
      alloc = 1'b1;
      m_head = 0; m_tail = 0; m_cnt = 0; m_epc = 0; m_mode = 0;

      // ---- reset for 2 cycles with alloc high
      tick(); tick();
      reset = 1'b0;
      alloc = 1'b0;
      #1;
      chk_regs("reset");
      chk("reset.rf_we", 64'(rf_we), 0);
      chk("reset.write_head", 64'(write_head), 0);
      chk("reset.req", 64'(dcache_wr_req), 0);
      chk("reset.flush", 64'(flush), 0);
      chk("reset.redirect", 64'(redirect_valid), 0);

      // ---- ALU retire: addu $3,$1,$2 value 0x55
      state_head = 3'd5;
      instr_head = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
      value_head = 32'h55;
      #1;
      chk("alu.rf_we", 64'(rf_we), 1);
      chk("alu.rf_waddr", 64'(rf_waddr), 3);
      chk("alu.rf_wdata", 64'(rf_wdata), 'h55);
      chk("alu.write_head", 64'(write_head), 'b100000);
      chk("alu.state_write", 64'(state_head_write), 0);
      tick();
      m_head = 1; m_cnt = 1;
      chk_regs("alu");

      // ---- sw at head: retired but no rf write
      instr_head = {6'h2B, 5'd4, 5'd5, 16'h0010};
      #1;
      chk("sw.rf_we", 64'(rf_we), 0);
      chk("sw.write_head", 64'(write_head), 'b100000);
      tick();
      m_head = 2; m_cnt = 2;
      chk_regs("sw");

      // ---- store: done 3 cycles after req rises
      state_head = 3'd3;
      addr_head  = 32'h100;
      value_head = 32'hAB;
      #1;
      chk("st.write_head", 64'(write_head), 'b100000);
      chk("st.state_write", 64'(state_head_write), 4);
      chk("st.req0", 64'(dcache_wr_req), 0);
      tick();
      chk_regs("st.issue");
      state_head = 3'd4;
      for (int k = 0; k < 4; k++) begin
         dcache_wr_done = (k == 3);
         #1;
         chk("st.req", 64'(dcache_wr_req), 1);
         chk("st.addr", 64'(dcache_wr_addr), 'h100);
         chk("st.data", 64'(dcache_wr_data), 'hAB);
         chk("st.wh", 64'(write_head), (k == 3) ? 'b100000 : 0);
         tick();
         if (k == 3) begin m_head = 3; m_cnt = 3; end
         chk_regs("st.wait");
      end
      dcache_wr_done = 1'b0;
      state_head = 3'd0;
      #1;
      chk("st.req_drop", 64'(dcache_wr_req), 0);

      // ---- exception at PC 0x40, mode 1; alloc in FLUSH ignored
      state_head = 3'd2;
      PC_head    = 32'h40;
      mode_head  = 1'b1;
      #1;
      chk("exc.flush0", 64'(flush), 0);
      chk("exc.wh", 64'(write_head), 0);
      tick();
      m_epc = 'h40; m_mode = 1;
      state_head = 3'd0;
      alloc = 1'b1;
      #1;
      chk("exc.flush", 64'(flush), 1);
      chk("exc.redirect", 64'(redirect_valid), 1);
      chk("exc.redirect_pc", 64'(redirect_pc), 'h2000);
      chk_regs("exc.flushcyc");
      tick();
      alloc = 1'b0;
      m_head = 0; m_tail = 0;
      chk_regs("exc.after");
      chk("exc.flush_drop", 64'(flush), 0);

      // ---- reset during STORE with done pending
      state_head = 3'd3;
      #1;
      tick();
      state_head = 3'd4;
      reset = 1'b1;
      dcache_wr_done = 1'b1;
      #1;
      chk("rst_st.req", 64'(dcache_wr_req), 1);
      tick();
      reset = 1'b0;
      dcache_wr_done = 1'b0;
      state_head = 3'd0;
      m_head = 0; m_tail = 0; m_cnt = 0; m_epc = 0; m_mode = 0;
      #1;
      chk("rst_st.req_drop", 64'(dcache_wr_req), 0);
      chk_regs("rst_st");

      // ---- wrap / full
      for (int k = 0; k < 9; k++) begin
         alloc = 1'b1;
         empty_entries = 4'(8 - k);
         note_alloc(0);
         tick();
         apply_alloc();
         chk("wrap.tail", 64'(tail), 64'(m_tail));
      end
      chk("wrap.tail_full", 64'(tail), 0);
      alloc = 1'b0;
      empty_entries = 4'd8;
      state_head = 3'd5;
      instr_head = {6'h09, 5'd1, 5'd2, 16'h0001};
      for (int k = 0; k < 8; k++) begin
         value_head = 32'(k);
         tick();
         m_head = (m_head + 1) % 8;
         m_cnt++;
         chk("wrap.head", 64'(head), 64'(m_head));
      end
      chk("wrap.retired8", 64'(retired_count), 8);

      // ---- simultaneous alloc + retire
      alloc = 1'b1;
      empty_entries = 4'd1;
      tick();
      alloc = 1'b0;
      state_head = 3'd0;
      m_head = 1; m_tail = 1; m_cnt = 9;
      chk_regs("simul");

      // ---- randomized sequence against the model
      for (int it = 0; it < 150; it++) begin
         int kind;
         kind = $urandom_range(0, 5);
         rand_alloc();
         state_head = 3'(kind);
         PC_head    = $urandom;
         addr_head  = $urandom;
         value_head = $urandom;
         mode_head  = 1'($urandom_range(0, 1));
         instr_head = $urandom;
         dcache_wr_done = 1'b0;
         case (kind)
            5: begin
               gen_instr($urandom_range(0, 7), ins, has, rd);
               instr_head = ins;
               #1;
               chk("r.alu.rf_we", 64'(rf_we), 64'(has));
               if (has) begin
                  chk("r.alu.waddr", 64'(rf_waddr), 64'(rd));
                  chk("r.alu.wdata", 64'(rf_wdata), 64'(value_head));
               end
               chk("r.alu.wh", 64'(write_head), 'b100000);
               chk("r.alu.shw", 64'(state_head_write), 0);
               note_alloc(0);
               tick();
               m_head = (m_head + 1) % 8;
               m_cnt++;
               apply_alloc();
               chk_regs("r.alu");
            end
            3: begin
               int n;
               logic [31:0] sa, sd;
               sa = addr_head; sd = value_head;
               n = $urandom_range(0, 3);
               #1;
               chk("r.st.shw", 64'(state_head_write), 4);
               chk("r.st.wh", 64'(write_head), 'b100000);
               note_alloc(0);
               tick();
               apply_alloc();
               chk_regs("r.st.issue");
               state_head = 3'd4;
               for (int k = 0; k <= n; k++) begin
                  rand_alloc();
                  dcache_wr_done = (k == n);
                  #1;
                  chk("r.st.req", 64'(dcache_wr_req), 1);
                  chk("r.st.addr", 64'(dcache_wr_addr), 64'(sa));
                  chk("r.st.data", 64'(dcache_wr_data), 64'(sd));
                  chk("r.st.wh", 64'(write_head), (k == n) ? 'b100000 : 0);
                  note_alloc(0);
                  tick();
                  if (k == n) begin
                     m_head = (m_head + 1) % 8;
                     m_cnt++;
                  end
                  apply_alloc();
                  chk_regs("r.st.wait");
               end
               dcache_wr_done = 1'b0;
            end
            2: begin
               #1;
               chk("r.exc.flush0", 64'(flush), 0);
               chk("r.exc.wh", 64'(write_head), 0);
               chk("r.exc.rf_we", 64'(rf_we), 0);
               note_alloc(0);
               tick();
               m_epc = PC_head;
               m_mode = int'(mode_head);
               apply_alloc();
               chk_regs("r.exc");
               rand_alloc();
               state_head = 3'd0;
               #1;
               chk("r.fl.flush", 64'(flush), 1);
               chk("r.fl.redir", 64'(redirect_valid), 1);
               chk("r.fl.pc", 64'(redirect_pc), 'h2000);
               chk("r.fl.wh", 64'(write_head), 0);
               tick();
               m_head = 0; m_tail = 0;
               chk_regs("r.fl");
            end
            default: begin
               #1;
               chk("r.wait.wh", 64'(write_head), 0);
               chk("r.wait.rf_we", 64'(rf_we), 0);
               chk("r.wait.req", 64'(dcache_wr_req), 0);
               chk("r.wait.flush", 64'(flush), 0);
               note_alloc(0);
               tick();
               apply_alloc();
               chk_regs("r.wait");
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
